// File: rtl/jump_pkg.sv
// Shared definitions for the doodle-jump game-control block.
// Contents:
//   game_state_t  - encoding of the game-state FSM (START / PLAY / FREEZE)
//   KEY_START     - USB keycode for Enter, starts or restarts a game
//   KEY_STOP      - USB keycode for Esc, freezes play
//   KEY_RESUME    - USB keycode for Space, resumes from freeze
package jump_pkg;

  typedef enum logic [2:0] {
    START  = 3'b000,
    PLAY   = 3'b001,
    FREEZE = 3'b010
  } game_state_t;

  localparam logic [7:0] KEY_START  = 8'd40;
  localparam logic [7:0] KEY_STOP   = 8'd41;
  localparam logic [7:0] KEY_RESUME = 8'd44;

endpackage

// File: rtl/jump_ctrl_if.sv
// Bundle of the game-control signals shared between the keyboard / physics
// side (master) and the jump_ctrl block (slave).
// Signals:
//   keycode     master->slave  current keyboard keycode, 0 = no key
//   cnt_clear   master->slave  synchronous clear of both counters
//   cnt_enable  master->slave  count enable for the fast counter
//   outstate    slave->master  game state code
//   loadplat    slave->master  platforms must be reloaded while high
//   count_fast  slave->master  fast (frame) counter value
//   count_slow  slave->master  slow counter value
interface jump_ctrl_if #(
  parameter int FAST_W = 7,
  parameter int SLOW_W = 2
);

  logic [7:0]        keycode;
  logic              cnt_clear;
  logic              cnt_enable;
  logic [2:0]        outstate;
  logic              loadplat;
  logic [FAST_W-1:0] count_fast;
  logic [SLOW_W-1:0] count_slow;

  modport master (
    output keycode, cnt_clear, cnt_enable,
    input  outstate, loadplat, count_fast, count_slow
  );

  modport slave (
    input  keycode, cnt_clear, cnt_enable,
    output outstate, loadplat, count_fast, count_slow
  );

endinterface

// File: rtl/jump_ctrl_up_counter.sv
// Generic wrapping up-counter used for the jump velocity-decay timers.
// Ports:
//   frame_clk  in   frame clock
//   Reset      in   asynchronous active-high reset to 0
//   clear      in   synchronous clear, wins over enable
//   enable     in   increment by one when high
//   out        out  counter value, wraps from all-ones to 0
module up_counter #(
  parameter int W = 4
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] out
);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      out <= '0;
    end else if (clear) begin
      out <= '0;
    end else if (enable) begin
      out <= out + 1'b1;
    end
  end

endmodule

// File: rtl/jump_ctrl.sv
// Frame-rate game-control block for the doodle-jump datapath.
// Decodes edge-detected USB keycodes into the START / PLAY / FREEZE game
// state, drives the platform-load strobe, and times jump velocity decay
// with two cascaded up-counters that only run while the game is in PLAY.
// Ports:
//   frame_clk  in   frame clock, one rising edge per video frame
//   Reset      in   asynchronous active-high reset
//   bus        slave side of jump_ctrl_if (keycode, counter controls in;
//              outstate, loadplat, count_fast, count_slow out)
module jump_ctrl #(
  parameter int         FAST_W     = 7,
  parameter int         SLOW_W     = 2,
  parameter int         SLOW_TAP   = 5,
  parameter logic [7:0] KEY_START  = 8'd40,
  parameter logic [7:0] KEY_STOP   = 8'd41,
  parameter logic [7:0] KEY_RESUME = 8'd44
) (
  input  logic        frame_clk,
  input  logic        Reset,
  jump_ctrl_if.slave  bus
);

  import jump_pkg::*;

  // Kept as a plain vector so that an out-of-range code can exist and be
  // recovered from, rather than being hidden by the enum type.
  logic [2:0]  state;
  game_state_t next_state;
  logic [7:0]  prev_key;

  logic hit_start;
  logic hit_stop;
  logic hit_resume;
  logic cnt_clear_eff;
  logic slow_enable;

  // A key only acts on the frame it first appears, so a held key fires once.
  assign hit_start  = (bus.keycode == KEY_START)  && (prev_key != KEY_START);
  assign hit_stop   = (bus.keycode == KEY_STOP)   && (prev_key != KEY_STOP);
  assign hit_resume = (bus.keycode == KEY_RESUME) && (prev_key != KEY_RESUME);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state    <= START;
      prev_key <= 8'd0;
    end else begin
      state    <= next_state;
      prev_key <= bus.keycode;
    end
  end

  always_comb begin
    next_state = START;
    case (state)
      START: begin
        if (hit_start) next_state = PLAY;
        else           next_state = START;
      end
      PLAY: begin
        if (hit_stop)       next_state = FREEZE;
        else if (hit_start) next_state = START;
        else                next_state = PLAY;
      end
      FREEZE: begin
        if (hit_resume)     next_state = PLAY;
        else if (hit_start) next_state = START;
        else                next_state = FREEZE;
      end
      default: next_state = START;
    endcase
  end

  // Counters are held at zero outside PLAY; the slow counter advances on
  // every enabled frame where the tapped fast-counter bit is set.
  always_comb begin
    bus.outstate  = state;
    bus.loadplat  = (state == START);
    cnt_clear_eff = bus.cnt_clear || (state != PLAY);
    slow_enable   = bus.cnt_enable && bus.count_fast[SLOW_TAP];
  end

  up_counter #(.W(FAST_W)) u_fast (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .clear     (cnt_clear_eff),
    .enable    (bus.cnt_enable),
    .out       (bus.count_fast)
  );

  up_counter #(.W(SLOW_W)) u_slow (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .clear     (cnt_clear_eff),
    .enable    (slow_enable),
    .out       (bus.count_slow)
  );

endmodule

// File: tb/tb_jump_ctrl.sv
// Self-checking bench for jump_ctrl: directed key sequences, counter wrap,
// clear, freeze, reset and illegal-state recovery, then random stimulus,
// all compared against a behavioural model of the game rules.
module tb_jump_ctrl;

  localparam int FAST_W   = 7;
  localparam int SLOW_W   = 2;
  localparam int SLOW_TAP = 5;
  localparam int FAST_MOD = 1 << FAST_W;
  localparam int SLOW_MOD = 1 << SLOW_W;
  localparam int TAP_DIV  = 1 << SLOW_TAP;

  // Model state codes: 0 START, 1 PLAY, 2 FREEZE, anything else illegal
  localparam int M_START  = 0;
  localparam int M_PLAY   = 1;
  localparam int M_FREEZE = 2;

  logic frame_clk = 1'b0;
  logic Reset;

  always #5 frame_clk = ~frame_clk;

  jump_ctrl_if #(.FAST_W(FAST_W), .SLOW_W(SLOW_W)) bus ();

  jump_ctrl #(
    .FAST_W   (FAST_W),
    .SLOW_W   (SLOW_W),
    .SLOW_TAP (SLOW_TAP)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus.master)
  );

  int compared;
  int mismatched;

  int m_state;
  int m_fast;
  int m_slow;
  int m_prev;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int key, input bit clr, input bit en);
    bus.keycode    = 8'(key);
    bus.cnt_clear  = clr;
    bus.cnt_enable = en;
  endtask

  function automatic void modelReset();
    m_state = M_START;
    m_fast  = 0;
    m_slow  = 0;
    m_prev  = 0;
  endfunction

  function automatic bit keyHit(input int k, input int want);
    return (k == want) && (m_prev != want);
  endfunction

  // Advances the model by one frame using the inputs present before the edge.
  function automatic void modelStep();
    int k;
    bit clr;
    bit en;
    int nf;
    int ns;
    int nst;
    k   = int'(bus.keycode);
    en  = bus.cnt_enable;
    clr = bus.cnt_clear || (m_state != M_PLAY);
    nf  = clr ? 0 : (en ? (m_fast + 1) % FAST_MOD : m_fast);
    ns  = clr ? 0 : ((en && ((m_fast / TAP_DIV) % 2 == 1)) ? (m_slow + 1) % SLOW_MOD : m_slow);
    case (m_state)
      M_START:  nst = keyHit(k, 40) ? M_PLAY : M_START;
      M_PLAY:   nst = keyHit(k, 41) ? M_FREEZE : (keyHit(k, 40) ? M_START : M_PLAY);
      M_FREEZE: nst = keyHit(k, 44) ? M_PLAY : (keyHit(k, 40) ? M_START : M_FREEZE);
      default:  nst = M_START;
    endcase
    m_state = nst;
    m_fast  = nf;
    m_slow  = ns;
    m_prev  = k;
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, ".state"}, 32'(bus.outstate), 32'(m_state));
    checkOutput({tag, ".loadplat"}, 32'(bus.loadplat), 32'(m_state == M_START));
    checkOutput({tag, ".fast"}, 32'(bus.count_fast), 32'(m_fast));
    checkOutput({tag, ".slow"}, 32'(bus.count_slow), 32'(m_slow));
  endtask

  task automatic tick(input string tag);
    if (!Reset) modelStep();
    @(posedge frame_clk);
    #1;
    checkAll(tag);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    Reset      = 1'b1;
    applyStimulus(0, 0, 0);
    modelReset();
    #2;
    checkAll("reset");
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;

    // Key pulse sequence through every legal transition
    applyStimulus(40, 0, 0); tick("key40");
    checkOutput("play_code", 32'(bus.outstate), 32'd1);
    applyStimulus(0, 0, 0);  tick("idle1");
    applyStimulus(41, 0, 0); tick("key41");
    checkOutput("freeze_code", 32'(bus.outstate), 32'd2);
    applyStimulus(0, 0, 0);  tick("idle2");
    applyStimulus(44, 0, 0); tick("key44");
    checkOutput("resume_code", 32'(bus.outstate), 32'd1);
    applyStimulus(0, 0, 0);  tick("idle3");
    applyStimulus(40, 0, 0); tick("restart");
    checkOutput("restart_code", 32'(bus.outstate), 32'd0);
    checkOutput("restart_load", 32'(bus.loadplat), 32'd1);

    // 130 enabled frames in PLAY: fast wraps to 2, slow saw 64 steps
    applyStimulus(0, 0, 0);  tick("idle4");
    applyStimulus(40, 0, 0); tick("play2");
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 130; i++) tick("count");
    checkOutput("wrap_fast", 32'(bus.count_fast), 32'd2);
    checkOutput("wrap_slow", 32'(bus.count_slow), 32'd0);

    // Clear together with enable at count 10
    for (int i = 0; i < 200 && m_fast != 10; i++) tick("to10");
    applyStimulus(0, 1, 1); tick("clear");
    checkOutput("clear_fast", 32'(bus.count_fast), 32'd0);
    applyStimulus(0, 0, 1); tick("after_clr1");
    checkOutput("after_clr1_fast", 32'(bus.count_fast), 32'd1);
    tick("after_clr2");

    // Freeze while counting at 50, then resume
    for (int i = 0; i < 200 && m_fast != 50; i++) tick("to50");
    applyStimulus(41, 0, 1); tick("freeze_edge");
    applyStimulus(0, 0, 1);  tick("frozen1");
    checkOutput("frozen_fast", 32'(bus.count_fast), 32'd0);
    tick("frozen2");
    tick("frozen3");
    applyStimulus(44, 0, 1); tick("resume");
    applyStimulus(0, 0, 1);  tick("resumed");
    checkOutput("resumed_fast", 32'(bus.count_fast), 32'd1);

    // Reset mid-count with Enter held
    applyStimulus(40, 0, 1); tick("to_start");
    applyStimulus(0, 0, 1);  tick("idle5");
    applyStimulus(40, 0, 1); tick("play3");
    for (int i = 0; i < 5; i++) tick("held_count");
    #2;
    Reset = 1'b1;
    modelReset();
    #1;
    checkAll("async_reset");
    tick("in_reset");
    #2;
    Reset = 1'b0;
    tick("post_reset");
    checkOutput("post_reset_code", 32'(bus.outstate), 32'd1);
    for (int i = 0; i < 3; i++) tick("held_no_restart");
    checkOutput("held_code", 32'(bus.outstate), 32'd1);

    // Illegal state recovery
    @(negedge frame_clk);
    force dut.state = 3'b111;
    #1;
    release dut.state;
    m_state = 7;
    checkAll("illegal");
    applyStimulus(0, 0, 1); tick("recover");
    checkOutput("recover_code", 32'(bus.outstate), 32'd0);

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      int key;
      r = int'($urandom_range(0, 9));
      if (r <= 3)      key = 0;
      else if (r == 4) key = 40;
      else if (r == 5) key = 41;
      else if (r == 6) key = 44;
      else if (r == 7) key = int'(bus.keycode);
      else             key = int'($urandom_range(0, 255));
      applyStimulus(key, $urandom_range(0, 15) == 0, $urandom_range(0, 7) != 0);
      tick("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
